// File: rtl/main_fsm_pkg.sv
// Shared encodings for the multicycle ARM control FSM: state names,
// datapath select codes, ALU operation codes and instruction field constants.
package main_fsm_pkg;

    // Controller states; numbering is fixed so traces line up with older dumps.
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECR   = 4'd6,
        EXECI   = 4'd7,
        ALUWB   = 4'd8,
        BRANCH  = 4'd9,
        UNKNOWN = 4'd10
    } state_t;

    // ALU B-operand select
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Result bus select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // ALU operation codes
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // Data-processing cmd field values the core implements
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Instruction class (instr[27:26])
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

endpackage

// File: rtl/main_fsm_alu_decoder.sv
// Combinational ALU decoder: turns the data-processing cmd field into an
// ALU operation, flag-write mask, CMP write suppression and a legality flag.
module alu_decoder
    import main_fsm_pkg::*;
(
    input  logic [3:0] cmd,
    input  logic       s,
    input  logic       dp,
    input  logic       alu_active,
    input  logic       flag_active,
    output logic [1:0] alu_control,
    output logic [1:0] flag_w,
    output logic       no_write,
    output logic       legal
);

    logic [1:0] op_sel;
    logic       arith;

    // Map cmd to ALU op; arith marks ops that produce meaningful C/V flags.
    always_comb begin
        op_sel = ALU_ADD;
        arith  = 1'b0;
        legal  = 1'b1;
        case (cmd)
            CMD_ADD: begin
                op_sel = ALU_ADD;
                arith  = 1'b1;
            end
            CMD_SUB: begin
                op_sel = ALU_SUB;
                arith  = 1'b1;
            end
            CMD_CMP: begin
                op_sel = ALU_SUB;
                arith  = 1'b1;
            end
            CMD_AND: op_sel = ALU_AND;
            CMD_ORR: op_sel = ALU_ORR;
            default: legal = 1'b0;
        endcase
    end

    // Outside the ALU states the ALU is just an adder for PC arithmetic.
    assign alu_control = alu_active ? op_sel : ALU_ADD;
    assign flag_w      = flag_active ? {s, s & arith} : 2'b00;
    assign no_write    = dp & (cmd == CMD_CMP);

endmodule

// File: rtl/main_fsm.sv
// Multicycle control FSM for the ARM core. Steps each instruction through
// fetch/decode/execute/memory/writeback and produces the datapath selects
// plus raw write strobes that the conditional-execution logic gates later.
module main_fsm
    import main_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic [1:0] FlagW,
    output logic       PCS,
    output logic       RegW,
    output logic       MemW,
    output logic       NoWrite,
    output logic       Illegal
);

    state_t     state;
    state_t     state_next;

    logic [3:0] cmd;
    logic       imm;
    logic       s_bit;
    logic       is_dp;
    logic       cmd_legal;
    logic       alu_active;
    logic       flag_active;
    logic [1:0] dec_flag_w;

    logic       ir_write_raw;
    logic       next_pc_raw;
    logic       reg_w_raw;
    logic       mem_w_raw;
    logic       pcs_raw;

    assign cmd   = Funct[4:1];
    assign imm   = Funct[5];
    assign s_bit = Funct[0];
    assign is_dp = (Op == OP_DP);

    assign alu_active  = (state == EXECR) || (state == EXECI) || (state == ALUWB);
    assign flag_active = (state == EXECR) || (state == EXECI);

    alu_decoder u_alu_decoder (
        .cmd         (cmd),
        .s           (s_bit),
        .dp          (is_dp),
        .alu_active  (alu_active),
        .flag_active (flag_active),
        .alu_control (ALUControl),
        .flag_w      (dec_flag_w),
        .no_write    (NoWrite),
        .legal       (cmd_legal)
    );

    // State register; reset drops straight back to FETCH, even mid-instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Sticky illegal flag, raised in the same edge that enters UNKNOWN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Illegal <= 1'b0;
        end else if (state_next == UNKNOWN) begin
            Illegal <= 1'b1;
        end
    end

    // Next-state selection; instruction fields only matter in DECODE and MEMADR.
    always_comb begin
        state_next = state;
        case (state)
            FETCH:   state_next = DECODE;
            DECODE: begin
                case (Op)
                    OP_MEM: state_next = MEMADR;
                    OP_BR:  state_next = BRANCH;
                    OP_DP: begin
                        if (!cmd_legal) begin
                            state_next = UNKNOWN;
                        end else if (imm) begin
                            state_next = EXECI;
                        end else begin
                            state_next = EXECR;
                        end
                    end
                    OP_ILL: state_next = UNKNOWN;
                endcase
            end
            MEMADR:  state_next = s_bit ? MEMRD : MEMWR;
            MEMRD:   state_next = MEMWB;
            MEMWB:   state_next = FETCH;
            MEMWR:   state_next = FETCH;
            EXECR:   state_next = ALUWB;
            EXECI:   state_next = ALUWB;
            ALUWB:   state_next = FETCH;
            BRANCH:  state_next = FETCH;
            UNKNOWN: state_next = UNKNOWN;
            default: state_next = FETCH;
        endcase
    end

    // Moore datapath selects and raw enables for each state.
    always_comb begin
        ir_write_raw = 1'b0;
        next_pc_raw  = 1'b0;
        reg_w_raw    = 1'b0;
        mem_w_raw    = 1'b0;
        pcs_raw      = 1'b0;
        AdrSrc       = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = SRCB_REG;
        ResultSrc    = RES_ALUOUT;
        case (state)
            FETCH: begin
                ir_write_raw = 1'b1;
                next_pc_raw  = 1'b1;
                ALUSrcA      = 1'b1;
                ALUSrcB      = SRCB_FOUR;
                ResultSrc    = RES_ALU;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
            end
            MEMADR: ALUSrcB = SRCB_IMM;
            MEMRD:  AdrSrc  = 1'b1;
            MEMWB: begin
                ResultSrc = RES_DATA;
                reg_w_raw = 1'b1;
                pcs_raw   = (Rd == 4'd15);
            end
            MEMWR: begin
                AdrSrc    = 1'b1;
                mem_w_raw = 1'b1;
            end
            EXECR: ALUSrcB = SRCB_REG;
            EXECI: ALUSrcB = SRCB_IMM;
            ALUWB: begin
                reg_w_raw = 1'b1;
                pcs_raw   = (Rd == 4'd15);
            end
            BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALU;
                pcs_raw   = 1'b1;
            end
            default: begin
                ir_write_raw = 1'b0;
            end
        endcase
    end

    // While reset is held every enable is silenced; selects follow FETCH.
    assign IRWrite = reset & ir_write_raw;
    assign NextPC  = reset & next_pc_raw;
    assign RegW    = reset & reg_w_raw;
    assign MemW    = reset & mem_w_raw;
    assign PCS     = reset & pcs_raw;
    assign FlagW   = reset ? dec_flag_w : 2'b00;

endmodule

// File: tb/tb_main_fsm.sv
// Self-checking bench for main_fsm: directed instructions plus random
// instruction streams with random mid-instruction resets, compared cycle by
// cycle against an instruction-level reference model.
module tb_main_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       IRWrite, NextPC, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ALUControl, FlagW;
    logic       PCS, RegW, MemW, NoWrite, Illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    main_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .IRWrite    (IRWrite),
        .NextPC     (NextPC),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ALUControl (ALUControl),
        .FlagW      (FlagW),
        .PCS        (PCS),
        .RegW       (RegW),
        .MemW       (MemW),
        .NoWrite    (NoWrite),
        .Illegal    (Illegal)
    );

    // Output vector order:
    // {IRWrite,NextPC,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUControl,FlagW,PCS,RegW,MemW,NoWrite,Illegal}
    function automatic logic [16:0] observe();
        return {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
                FlagW, PCS, RegW, MemW, NoWrite, Illegal};
    endfunction

    task automatic checkOutput(input string tag, input logic [16:0] observed, input logic [16:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%05h expected=%05h", tag, observed, expected);
        end
    endtask

    function automatic bit legalCmd(input logic [3:0] c);
        return c inside {4'b0000, 4'b0010, 4'b0100, 4'b1100, 4'b1010};
    endfunction

    function automatic bit badInstr(input logic [1:0] op, input logic [5:0] funct);
        return (op == 2'b11) || (op == 2'b00 && !legalCmd(funct[4:1]));
    endfunction

    // Cycles spent per instruction; bad ones are watched for 6 cycles stuck.
    function automatic int instrLen(input logic [1:0] op, input logic [5:0] funct);
        if (badInstr(op, funct)) return 8;
        if (op == 2'b01) return funct[0] ? 5 : 4;
        if (op == 2'b10) return 3;
        return 4;
    endfunction

    function automatic logic [1:0] aluFor(input logic [3:0] c);
        case (c)
            4'b0100: return 2'b00;
            4'b0010: return 2'b01;
            4'b1010: return 2'b01;
            4'b0000: return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    // Expected outputs at cycle 'phase' of an instruction, from the ISA-level rules.
    function automatic logic [16:0] model(input logic [1:0] op, input logic [5:0] funct,
                                          input logic [3:0] rd, input int phase);
        logic       irw = 0, npc = 0, adr = 0, srca = 0, pcs = 0, regw = 0, memw = 0, nowr, ill = 0;
        logic [1:0] srcb = 0, res = 0, aluc = 0, flg = 0;
        logic [3:0] c = funct[4:1];
        nowr = (op == 2'b00) && (c == 4'b1010);
        if (phase == 0) begin
            irw = 1; npc = 1; srca = 1; srcb = 2; res = 2;
        end else if (phase == 1) begin
            srca = 1; srcb = 2; res = 2;
        end else if (badInstr(op, funct)) begin
            ill = 1;
        end else if (op == 2'b01) begin
            if (phase == 2) srcb = 1;
            else if (!funct[0]) begin adr = 1; memw = 1; end
            else if (phase == 3) adr = 1;
            else begin res = 1; regw = 1; pcs = (rd == 4'd15); end
        end else if (op == 2'b10) begin
            srcb = 1; res = 2; pcs = 1;
        end else begin
            aluc = aluFor(c);
            if (phase == 2) begin
                srcb = funct[5] ? 2'd1 : 2'd0;
                flg  = {funct[0], funct[0] & (c inside {4'b0100, 4'b0010, 4'b1010})};
            end else begin
                regw = 1; pcs = (rd == 4'd15);
            end
        end
        return {irw, npc, adr, srca, srcb, res, aluc, flg, pcs, regw, memw, nowr, ill};
    endfunction

    function automatic logic [16:0] resetModel(input logic [1:0] op, input logic [5:0] funct);
        logic nowr = (op == 2'b00) && (funct[4:1] == 4'b1010);
        return {1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, nowr, 1'b0};
    endfunction

    // Called at posedge+1; leaves reset released at posedge+1 with state in FETCH.
    task automatic doReset(input string name);
        reset = 1'b0;
        #1;
        checkOutput($sformatf("%s rstImm", name), observe(), resetModel(Op, Funct));
        @(negedge clk);
        checkOutput($sformatf("%s rstLow", name), observe(), resetModel(Op, Funct));
        @(posedge clk); #1;
        checkOutput($sformatf("%s rstHold", name), observe(), resetModel(Op, Funct));
        reset = 1'b1;
    endtask

    // Runs one instruction from FETCH; resetAt >= 0 pulses reset at that cycle.
    task automatic applyStimulus(input logic [1:0] op, input logic [5:0] funct,
                                 input logic [3:0] rd, input int resetAt, input string name);
        int len;
        Op = op; Funct = funct; Rd = rd;
        len = instrLen(op, funct);
        for (int p = 0; p < len; p++) begin
            if (p == resetAt) begin
                doReset(name);
                return;
            end
            @(negedge clk);
            checkOutput($sformatf("%s p%0d", name, p), observe(), model(op, funct, rd, p));
            @(posedge clk); #1;
        end
        if (badInstr(op, funct)) doReset(name);
    endtask

    initial begin
        logic [1:0] rop;
        logic [5:0] rfunct;
        logic [3:0] rcmd;
        int         rlen;
        int         rrst;
        logic [3:0] legalList [5] = '{4'b0000, 4'b0010, 4'b0100, 4'b1100, 4'b1010};

        reset = 1'b0; Op = 2'b00; Funct = 6'd0; Rd = 4'd0;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("resetState", observe(), resetModel(2'b00, 6'd0));
        @(posedge clk); #1;
        reset = 1'b1;

        applyStimulus(2'b00, {1'b0, 4'b0100, 1'b1}, 4'd3,  -1, "addReg");
        applyStimulus(2'b01, 6'b000001,             4'd15, -1, "ldrPc");
        applyStimulus(2'b01, 6'b000000,             4'd2,  -1, "str");
        applyStimulus(2'b00, {1'b1, 4'b1010, 1'b1}, 4'd0,  -1, "cmpImm");
        applyStimulus(2'b10, 6'b000000,             4'd0,  -1, "branch");
        applyStimulus(2'b11, 6'b000000,             4'd0,  -1, "opIll");
        applyStimulus(2'b00, {1'b0, 4'b0001, 1'b0}, 4'd0,  -1, "cmdIll");
        applyStimulus(2'b01, 6'b000001,             4'd5,   3, "ldrRst");
        applyStimulus(2'b00, {1'b1, 4'b1100, 1'b0}, 4'd15, -1, "orrPc");

        for (int i = 0; i < 150; i++) begin
            rop  = 2'($urandom_range(0, 3));
            rcmd = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                               : legalList[$urandom_range(0, 4)];
            rfunct = {1'($urandom_range(0, 1)), rcmd, 1'($urandom_range(0, 1))};
            rlen = instrLen(rop, rfunct);
            rrst = ($urandom_range(0, 9) == 0) ? $urandom_range(0, rlen - 1) : -1;
            applyStimulus(rop, rfunct, 4'($urandom_range(0, 15)), rrst, $sformatf("rnd%0d", i));
        end

        applyStimulus(2'b10, 6'b000000, 4'd0, -1, "tail");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
